// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the RX state encoding.
//   BaudCnt   - default clock cycles per bit
//   FrameBits - bits per 8N1 frame (start + 8 data + stop)
//   rx_state_t - receiver FSM states
package uart_pkg;
  localparam int BaudCnt = 108;
  localparam int FrameBits = 10;
  typedef enum logic [2:0] {stIdle, stStart, stData, stStop, stWtHigh} rx_state_t;
endpackage

// File: rtl/rx_bit_sync.sv
// rx_bit_sync: 2-FF synchronizer for the serial line plus a registered copy for edge detection.
//   Clk, RstB    - clock, async active-high reset (all flops reset to line idle = 1)
//   SerialDataIn - asynchronous serial line
//   rRxSync      - synchronized line
//   rRxPrev      - rRxSync delayed one cycle
module rx_bit_sync (
  input  logic Clk,
  input  logic RstB,
  input  logic SerialDataIn,
  output logic rRxSync,
  output logic rRxPrev
);
  logic meta;
  always_ff @(posedge Clk or posedge RstB)
    if (RstB) begin
      meta    <= 1'b1;
      rRxSync <= 1'b1;
      rRxPrev <= 1'b1;
    end else begin
      meta    <= SerialDataIn;
      rRxSync <= meta;
      rRxPrev <= rRxSync;
    end
endmodule

// File: rtl/rx_uart.sv
// rx_uart: oversampling 8N1 UART receiver feeding an RX FIFO.
//   Clk, RstB    - clock, async active-high reset
//   SerialDataIn - asynchronous serial line, idles high
//   RxFfFull     - FIFO full, only looked at in the stop-sample cycle
//   RxFfWrEn     - one-cycle FIFO write strobe
//   RxFfWrData   - received byte, holds the last written byte
//   FrameErr     - one-cycle pulse on a low stop bit
//   OvrErr       - one-cycle pulse when a good byte is dropped on FIFO full
module rx_uart
  import uart_pkg::*;
#(
  parameter int cbaudCnt = BaudCnt,
  parameter int cHalfCnt = cbaudCnt / 2
) (
  input  logic       Clk,
  input  logic       RstB,
  input  logic       SerialDataIn,
  input  logic       RxFfFull,
  output logic       RxFfWrEn,
  output logic [7:0] RxFfWrData,
  output logic       FrameErr,
  output logic       OvrErr
);
  rx_state_t   state;
  logic        rx_sync, rx_prev;
  logic [9:0]  baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        expire;
  rx_bit_sync u_sync (
    .Clk          (Clk),
    .RstB         (RstB),
    .SerialDataIn (SerialDataIn),
    .rRxSync      (rx_sync),
    .rRxPrev      (rx_prev)
  );
  assign expire = baud_cnt == 10'd1;
  always_ff @(posedge Clk or posedge RstB)
    if (RstB) begin
      state      <= stIdle;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      RxFfWrEn   <= 1'b0;
      RxFfWrData <= '0;
      FrameErr   <= 1'b0;
      OvrErr     <= 1'b0;
    end else begin
      RxFfWrEn <= 1'b0;
      FrameErr <= 1'b0;
      OvrErr   <= 1'b0;
      case (state)
        stIdle:
          if (rx_prev && !rx_sync) begin
            baud_cnt <= 10'(cHalfCnt);
            state    <= stStart;
          end
        stStart:
          if (!expire) baud_cnt <= baud_cnt - 10'd1;
          else if (rx_sync) state <= stIdle;
          else begin
            baud_cnt <= 10'(cbaudCnt);
            bit_cnt  <= '0;
            state    <= stData;
          end
        stData:
          if (!expire) baud_cnt <= baud_cnt - 10'd1;
          else begin
            shift    <= {rx_sync, shift[7:1]};
            baud_cnt <= 10'(cbaudCnt);
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= stStop;
          end
        stStop:
          if (!expire) baud_cnt <= baud_cnt - 10'd1;
          else begin
            RxFfWrEn <= rx_sync && !RxFfFull;
            OvrErr   <= rx_sync && RxFfFull;
            FrameErr <= !rx_sync;
            if (rx_sync && !RxFfFull) RxFfWrData <= shift;
            state    <= rx_sync ? stIdle : stWtHigh;
          end
        // A low stop bit may be a break; wait for the line to return high before re-arming.
        stWtHigh:
          if (rx_sync) state <= stIdle;
        default: state <= stIdle;
      endcase
    end
endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: directed self-checking bench for rx_uart.
module tb_rx_uart;
  import uart_pkg::*;
  localparam int B = 108;
  logic       Clk = 1'b0;
  logic       RstB = 1'b1;
  logic       SerialDataIn = 1'b1;
  logic       RxFfFull = 1'b0;
  logic       RxFfWrEn;
  logic [7:0] RxFfWrData;
  logic       FrameErr;
  logic       OvrErr;
  int applied = 0;
  int miss = 0;
  int cyc = 0;
  int last_fall = 0;
  int fe_n = 0;
  int ov_n = 0;
  int multi = 0;
  logic [7:0] wr_d[$];
  int         wr_c[$];
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       full;
    int         low_hold;
    int         exp_wr;
    int         exp_fe;
    int         exp_ov;
    logic       chk_t;
  } vec_t;
  vec_t vt[5];
  rx_uart #(.cbaudCnt(B)) dut (
    .Clk          (Clk),
    .RstB         (RstB),
    .SerialDataIn (SerialDataIn),
    .RxFfFull     (RxFfFull),
    .RxFfWrEn     (RxFfWrEn),
    .RxFfWrData   (RxFfWrData),
    .FrameErr     (FrameErr),
    .OvrErr       (OvrErr)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk)
    if (!RstB) begin
      if (RxFfWrEn) begin
        wr_d.push_back(RxFfWrData);
        wr_c.push_back(cyc);
      end
      if (FrameErr) fe_n = fe_n + 1;
      if (OvrErr) ov_n = ov_n + 1;
      if (int'(RxFfWrEn) + int'(FrameErr) + int'(OvrErr) > 1) multi = multi + 1;
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_ev();
    wr_d.delete();
    wr_c.delete();
    fe_n = 0;
    ov_n = 0;
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < FrameBits; i++) begin
      SerialDataIn = fr[i];
      if (i == 0) last_fall = cyc;
      repeat (B) @(negedge Clk);
    end
  endtask
  task automatic idle(input int n);
    SerialDataIn = 1'b1;
    repeat (n) @(negedge Clk);
  endtask
  initial begin
    vt[0] = '{8'h55, 1'b1, 1'b0, 0,   1, 0, 0, 1'b1};
    vt[1] = '{8'h42, 1'b1, 1'b1, 0,   0, 0, 1, 1'b0};
    vt[2] = '{8'h43, 1'b1, 1'b0, 0,   1, 0, 0, 1'b0};
    vt[3] = '{8'h81, 1'b0, 1'b0, 500, 0, 1, 0, 1'b0};
    vt[4] = '{8'h7E, 1'b1, 1'b0, 0,   1, 0, 0, 1'b0};
    repeat (3) @(negedge Clk);
    check("rst_wren", {31'd0, RxFfWrEn}, 0);
    check("rst_data", {24'd0, RxFfWrData}, 0);
    check("rst_fe", {31'd0, FrameErr}, 0);
    check("rst_ov", {31'd0, OvrErr}, 0);
    RstB = 1'b0;
    idle(20);
    for (int v = 0; v < 5; v++) begin
      clear_ev();
      RxFfFull = vt[v].full;
      send(vt[v].d, vt[v].stop);
      RxFfFull = 1'b0;
      if (vt[v].low_hold > 0) begin
        SerialDataIn = 1'b0;
        repeat (vt[v].low_hold) @(negedge Clk);
      end
      idle(40);
      check($sformatf("v%0d_wr_cnt", v), wr_d.size(), vt[v].exp_wr);
      check($sformatf("v%0d_fe_cnt", v), fe_n, vt[v].exp_fe);
      check($sformatf("v%0d_ov_cnt", v), ov_n, vt[v].exp_ov);
      if (wr_d.size() > 0 && vt[v].exp_wr > 0) begin
        check($sformatf("v%0d_data", v), {24'd0, wr_d[0]}, {24'd0, vt[v].d});
        check($sformatf("v%0d_hold", v), {24'd0, RxFfWrData}, {24'd0, vt[v].d});
        if (vt[v].chk_t) check("strobe_time", wr_c[0] - last_fall, 1029);
      end
    end
    clear_ev();
    send(8'hA3, 1'b1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(40);
    check("b2b_cnt", wr_d.size(), 3);
    if (wr_d.size() == 3) begin
      check("b2b_d0", {24'd0, wr_d[0]}, 32'hA3);
      check("b2b_d1", {24'd0, wr_d[1]}, 32'h00);
      check("b2b_d2", {24'd0, wr_d[2]}, 32'hFF);
      check("b2b_gap1", wr_c[1] - wr_c[0], 1080);
      check("b2b_gap2", wr_c[2] - wr_c[1], 1080);
    end
    check("b2b_err", fe_n + ov_n, 0);
    clear_ev();
    SerialDataIn = 1'b0;
    last_fall = cyc;
    repeat (20) @(negedge Clk);
    SerialDataIn = 1'b1;
    while (cyc < last_fall + 2 + 56) @(negedge Clk);
    check("glitch_idle", {29'd0, dut.state}, {29'd0, stIdle});
    idle(200);
    check("glitch_ev", wr_d.size() + fe_n + ov_n, 0);
    send(8'h3C, 1'b1);
    idle(40);
    check("after_glitch_cnt", wr_d.size(), 1);
    if (wr_d.size() == 1) check("after_glitch_data", {24'd0, wr_d[0]}, 32'h3C);
    clear_ev();
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h99, 1'b0};
      for (int i = 0; i < 5; i++) begin
        SerialDataIn = fr[i];
        repeat (i == 4 ? B / 2 : B) @(negedge Clk);
      end
    end
    RstB = 1'b1;
    #1;
    check("mid_rst_wren", {31'd0, RxFfWrEn}, 0);
    check("mid_rst_data", {24'd0, RxFfWrData}, 0);
    check("mid_rst_fe", {31'd0, FrameErr}, 0);
    check("mid_rst_ov", {31'd0, OvrErr}, 0);
    check("mid_rst_state", {29'd0, dut.state}, {29'd0, stIdle});
    repeat (3) @(negedge Clk);
    RstB = 1'b0;
    idle(1200);
    check("abort_ev", wr_d.size() + fe_n + ov_n, 0);
    send(8'h5A, 1'b1);
    idle(40);
    check("after_rst_cnt", wr_d.size(), 1);
    if (wr_d.size() == 1) check("after_rst_data", {24'd0, wr_d[0]}, 32'h5A);
    check("one_pulse_per_cycle", multi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end
endmodule
